// File: rtl/microcode_sequencer.sv
// Microcode sequencer: dispatches microprograms from a writable label table and
// steps through a writable control store with branch, call and return micro-ops.
module microcode_sequencer #(
  parameter int CTRL_W      = 32,
  parameter int UPC_W       = 10,
  parameter int OP_W        = 8,
  parameter int MODE_W      = 1,
  parameter int NCOND       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [MODE_W-1:0]       mode,
  input  logic [OP_W-1:0]         opcode,
  input  logic [NCOND-1:0]        cond,
  input  logic                    mc_stall,
  input  logic                    kill,
  input  logic                    cs_we,
  input  logic [UPC_W-1:0]        cs_addr,
  input  logic [CTRL_W-1:0]       cs_wdata,
  input  logic                    lbl_we,
  input  logic [MODE_W+OP_W-1:0]  lbl_addr,
  input  logic [UPC_W:0]          lbl_wdata,
  output logic [CTRL_W-1:0]       mc_control,
  output logic                    mc_more,
  output logic                    mc_valid,
  output logic [UPC_W-1:0]        mc_upc,
  output logic                    mc_err
);

  localparam int CSEL_W = (NCOND > 1) ? $clog2(NCOND) : 1;
  localparam int LBL_W  = MODE_W + OP_W;
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    SEQ_NEXT   = 2'b00,
    SEQ_BRANCH = 2'b01,
    SEQ_CALL   = 2'b10,
    SEQ_RET    = 2'b11
  } seq_e;

  logic [CTRL_W-1:0] cs_mem    [2**UPC_W];
  logic [UPC_W:0]    lbl_mem   [2**LBL_W];
  logic [UPC_W-1:0]  stack_mem [STACK_DEPTH];

  logic [CTRL_W-1:0] op_q;
  logic [UPC_W-1:0]  upc_q;
  logic              valid_q;
  logic [SP_W-1:0]   sp_q;
  logic              err_q;

  logic [CTRL_W-1:0] nxt_op;
  logic [UPC_W-1:0]  nxt_upc;
  logic              nxt_valid;
  logic [SP_W-1:0]   nxt_sp;
  logic              nxt_err;
  logic              push;

  seq_e              seq;
  logic [CSEL_W-1:0] csel;
  logic [UPC_W-1:0]  target;
  logic [UPC_W-1:0]  upc_inc;
  logic [UPC_W:0]    lbl_entry;
  logic              cond_hit;
  logic              stack_full;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
  logic              advance;

  assign seq        = seq_e'(op_q[2:1]);
  assign csel       = op_q[2+CSEL_W:3];
  assign target     = op_q[UPC_W+2+CSEL_W:3+CSEL_W];
  assign upc_inc    = upc_q + UPC_W'(1);
  assign lbl_entry  = lbl_mem[{mode, opcode}];
  assign stack_full = (sp_q == SP_W'(STACK_DEPTH));
  assign top_idx    = IDX_W'(sp_q - SP_W'(1));
  // A call on a full stack overwrites the top entry rather than growing.
  assign push_idx   = stack_full ? IDX_W'(STACK_DEPTH - 1) : IDX_W'(sp_q);
  assign advance    = kill | ~mc_stall;

  // Decoded compare keeps a non-power-of-two NCOND from indexing past cond.
  always_comb begin
    cond_hit = 1'b0;
    for (int i = 0; i < NCOND; i++) begin
      if (csel == CSEL_W'(i)) cond_hit = cond[i];
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    nxt_upc   = lbl_entry[UPC_W-1:0];
    nxt_valid = lbl_entry[UPC_W];
    nxt_sp    = sp_q;
    nxt_err   = err_q;
    push      = 1'b0;
    if (kill) begin
      nxt_sp = '0;
    end else if (op_q[0]) begin
      unique case (seq)
        SEQ_NEXT: begin
          nxt_upc   = upc_inc;
          nxt_valid = 1'b1;
        end
        SEQ_BRANCH: begin
          nxt_upc   = cond_hit ? target : upc_inc;
          nxt_valid = 1'b1;
        end
        SEQ_CALL: begin
          nxt_upc   = target;
          nxt_valid = 1'b1;
          push      = 1'b1;
          if (stack_full) nxt_err = 1'b1;
          else            nxt_sp  = sp_q + SP_W'(1);
        end
        SEQ_RET: begin
          if (sp_q == '0) begin
            nxt_err = 1'b1;
          end else begin
            nxt_upc   = stack_mem[top_idx];
            nxt_valid = 1'b1;
            nxt_sp    = sp_q - SP_W'(1);
          end
        end
      endcase
    end
  end

  assign nxt_op = nxt_valid ? cs_mem[nxt_upc] : '0;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q    <= '0;
      upc_q   <= '0;
      valid_q <= 1'b0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else if (advance) begin
      op_q    <= nxt_op;
      upc_q   <= nxt_upc;
      valid_q <= nxt_valid;
      sp_q    <= nxt_sp;
      err_q   <= nxt_err;
    end
  end

  // NOTE: storage arrays carry no reset; their contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (cs_we)  cs_mem[cs_addr]   <= cs_wdata;
    if (lbl_we) lbl_mem[lbl_addr] <= lbl_wdata;
    if (advance && push) stack_mem[push_idx] <= upc_inc;
  end

  always_comb begin
    mc_control = op_q;
    mc_more    = op_q[0];
    mc_valid   = valid_q;
    if (kill) begin
      mc_control = '0;
      mc_more    = 1'b0;
      mc_valid   = 1'b0;
    end else if (mc_stall) begin
      mc_control    = '0;
      mc_control[0] = op_q[0];
      mc_valid      = 1'b0;
    end
  end

  assign mc_upc = upc_q;
  assign mc_err = err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed and randomized bench for microcode_sequencer, checked against a
// queue-based behavioural model of the sequencing rules.
module tb_microcode_sequencer;

  localparam int CTRL_W      = 32;
  localparam int UPC_W       = 10;
  localparam int OP_W        = 8;
  localparam int MODE_W      = 1;
  localparam int NCOND       = 4;
  localparam int STACK_DEPTH = 4;
  localparam int CSEL_W      = 2;
  localparam int LBL_W       = MODE_W + OP_W;
  localparam int UPC_N       = 1 << UPC_W;
  localparam int LBL_N       = 1 << LBL_W;

  logic                clk = 1'b0;
  logic                rst_b;
  logic [MODE_W-1:0]   mode;
  logic [OP_W-1:0]     opcode;
  logic [NCOND-1:0]    cond;
  logic                mc_stall;
  logic                kill;
  logic                cs_we;
  logic [UPC_W-1:0]    cs_addr;
  logic [CTRL_W-1:0]   cs_wdata;
  logic                lbl_we;
  logic [LBL_W-1:0]    lbl_addr;
  logic [UPC_W:0]      lbl_wdata;
  logic [CTRL_W-1:0]   mc_control;
  logic                mc_more;
  logic                mc_valid;
  logic [UPC_W-1:0]    mc_upc;
  logic                mc_err;

  microcode_sequencer #(
    .CTRL_W(CTRL_W), .UPC_W(UPC_W), .OP_W(OP_W), .MODE_W(MODE_W),
    .NCOND(NCOND), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .rst_b(rst_b), .mode(mode), .opcode(opcode), .cond(cond),
    .mc_stall(mc_stall), .kill(kill), .cs_we(cs_we), .cs_addr(cs_addr),
    .cs_wdata(cs_wdata), .lbl_we(lbl_we), .lbl_addr(lbl_addr), .lbl_wdata(lbl_wdata),
    .mc_control(mc_control), .mc_more(mc_more), .mc_valid(mc_valid),
    .mc_upc(mc_upc), .mc_err(mc_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk      = 1'b1;

  // Reference model state.
  bit [CTRL_W-1:0] cs_m  [UPC_N];
  bit [UPC_W:0]    lbl_m [LBL_N];
  int              m_upc   = 0;
  bit              m_valid = 1'b0;
  bit [CTRL_W-1:0] m_word  = '0;
  bit              m_err   = 1'b0;
  int              stk[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [CTRL_W-1:0] mk(input int more, input int seq, input int sel, input int tgt);
    return CTRL_W'(tgt * (1 << (3 + CSEL_W)) + sel * 8 + seq * 2 + more);
  endfunction

  function automatic void m_goto(input int u);
    m_upc   = u % UPC_N;
    m_valid = 1'b1;
    m_word  = cs_m[m_upc];
  endfunction

  function automatic void m_dispatch();
    int e;
    e       = int'(lbl_m[{mode, opcode}]);
    m_upc   = e % UPC_N;
    m_valid = (e / UPC_N) != 0;
    m_word  = m_valid ? cs_m[m_upc] : '0;
  endfunction

  function automatic void m_step();
    int seq, sel, tgt, ret;
    if (kill) begin
      m_dispatch();
      stk.delete();
    end else if (!mc_stall) begin
      if (m_word[0]) begin
        seq = int'((m_word >> 1) & 3);
        sel = int'((m_word >> 3) & ((1 << CSEL_W) - 1));
        tgt = int'((m_word >> (3 + CSEL_W)) % UPC_N);
        ret = (m_upc + 1) % UPC_N;
        case (seq)
          0: m_goto(ret);
          1: m_goto((sel < NCOND && cond[sel]) ? tgt : ret);
          2: begin
            if (stk.size() == STACK_DEPTH) begin
              stk[stk.size() - 1] = ret;
              m_err = 1'b1;
            end else begin
              stk.push_back(ret);
            end
            m_goto(tgt);
          end
          default: begin
            if (stk.size() == 0) begin
              m_err = 1'b1;
              m_dispatch();
            end else begin
              m_goto(stk.pop_back());
            end
          end
        endcase
      end else begin
        m_dispatch();
      end
    end
    if (cs_we)  cs_m[cs_addr]   = cs_wdata;
    if (lbl_we) lbl_m[lbl_addr] = lbl_wdata;
  endfunction

  task automatic eval();
    logic [CTRL_W-1:0] exp_ctrl;
    #1;
    if (chk) begin
      exp_ctrl = kill ? '0 : (mc_stall ? CTRL_W'(m_word[0]) : m_word);
      check("m_upc",   64'(mc_upc),     64'(m_upc));
      check("m_valid", 64'(mc_valid),   64'(!kill && !mc_stall && m_valid));
      check("m_more",  64'(mc_more),    64'(!kill && m_word[0]));
      check("m_ctrl",  64'(mc_control), 64'(exp_ctrl));
      check("m_err",   64'(mc_err),     64'(m_err));
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic tick();
    eval();
    clk_edge();
  endtask

  task automatic expect_upc(input string tag, input int upc);
    eval();
    check(tag, 64'(mc_upc), 64'(upc));
    check({tag, "_v"}, 64'(mc_valid), 64'(1));
    clk_edge();
  endtask

  task automatic wr_cs(input int a, input bit [CTRL_W-1:0] d);
    cs_we = 1'b1; cs_addr = UPC_W'(a); cs_wdata = d;
    tick();
    cs_we = 1'b0;
  endtask

  task automatic wr_lbl(input int a, input int d);
    lbl_we = 1'b1; lbl_addr = LBL_W'(a); lbl_wdata = (UPC_W + 1)'(d);
    tick();
    lbl_we = 1'b0;
  endtask

  initial begin
    rst_b = 1'b1; mode = '0; opcode = '0; cond = '0; mc_stall = 1'b0; kill = 1'b0;
    cs_we = 1'b0; cs_addr = '0; cs_wdata = '0; lbl_we = 1'b0; lbl_addr = '0; lbl_wdata = '0;
    #2 rst_b = 1'b0;
    @(negedge clk);
    eval();
    check("rst_ctrl",  64'(mc_control), 64'(0));
    check("rst_valid", 64'(mc_valid),   64'(0));
    check("rst_upc",   64'(mc_upc),     64'(0));
    @(negedge clk);
    rst_b = 1'b1;

    // Fill both tables with known contents; kill keeps the sequencer idle.
    chk  = 1'b0;
    kill = 1'b1;
    for (int i = 0; i < UPC_N; i++) begin
      cs_we = 1'b1; cs_addr = UPC_W'(i); cs_wdata = '0;
      lbl_we = (i < LBL_N); lbl_addr = LBL_W'(i); lbl_wdata = '0;
      clk_edge();
    end
    cs_we = 1'b0; lbl_we = 1'b0;
    clk_edge();
    chk = 1'b1;

    // Straight-line program with redispatch.
    wr_lbl(12'h012, 12'h440);
    wr_cs(12'h040, mk(1, 0, 0, 0));
    wr_cs(12'h041, mk(1, 0, 0, 0));
    wr_cs(12'h042, mk(0, 0, 0, 0));
    kill = 1'b0; opcode = 8'h12;
    tick();
    expect_upc("seq_0", 12'h040);
    expect_upc("seq_1", 12'h041);
    expect_upc("seq_2", 12'h042);
    expect_upc("seq_redisp", 12'h040);

    // Conditional branch, taken then not taken.
    kill = 1'b1; opcode = 8'h00;
    wr_cs(12'h040, mk(1, 1, 2, 12'h080));
    wr_cs(12'h080, mk(0, 0, 0, 0));
    opcode = 8'h12;
    tick();
    kill = 1'b0; cond = 4'b0100;
    expect_upc("br_at", 12'h040);
    expect_upc("br_taken", 12'h080);
    cond = 4'b0000;
    expect_upc("br_at2", 12'h040);
    expect_upc("br_fall", 12'h041);

    // Call and return.
    kill = 1'b1; opcode = 8'h00;
    wr_cs(12'h040, mk(1, 2, 0, 12'h100));
    wr_cs(12'h100, mk(1, 3, 0, 0));
    opcode = 8'h12;
    tick();
    kill = 1'b0;
    expect_upc("call_0", 12'h040);
    expect_upc("call_1", 12'h100);
    expect_upc("call_ret", 12'h041);
    check("call_err", 64'(mc_err), 64'(0));

    // Five nested calls overflow a four-entry stack.
    kill = 1'b1; opcode = 8'h00;
    for (int i = 0; i < 4; i++) wr_cs(12'h100 + i, mk(1, 2, 0, 12'h101 + i));
    wr_cs(12'h104, mk(1, 3, 0, 0));
    opcode = 8'h12;
    tick();
    kill = 1'b0;
    expect_upc("nest_1", 12'h040);
    expect_upc("nest_2", 12'h100);
    expect_upc("nest_3", 12'h101);
    expect_upc("nest_4", 12'h102);
    eval();
    check("nest_err_pre", 64'(mc_err), 64'(0));
    clk_edge();
    eval();
    check("nest_upc5", 64'(mc_upc), 64'(12'h104));
    check("nest_err_post", 64'(mc_err), 64'(1));

    // Return on an empty stack redispatches from the label table.
    kill = 1'b1; opcode = 8'h00;
    wr_lbl(12'h020, 12'h504);
    opcode = 8'h20;
    tick();
    kill = 1'b0; opcode = 8'h12;
    expect_upc("uflow_ret", 12'h104);
    eval();
    check("uflow_upc", 64'(mc_upc), 64'(12'h040));
    check("uflow_err", 64'(mc_err), 64'(1));
    clk_edge();

    // Stall mid-program holds state and masks the control word.
    kill = 1'b1;
    wr_cs(12'h040, mk(1, 0, 0, 0));
    tick();
    kill = 1'b0;
    expect_upc("stall_pre", 12'h040);
    mc_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eval();
      check("stall_upc",   64'(mc_upc),     64'(12'h041));
      check("stall_ctrl",  64'(mc_control), 64'(1));
      check("stall_valid", 64'(mc_valid),   64'(0));
      clk_edge();
    end
    mc_stall = 1'b0;
    expect_upc("stall_resume", 12'h041);
    expect_upc("stall_next", 12'h042);

    // Kill wins over stall and redispatches.
    expect_upc("kill_pre0", 12'h040);
    mc_stall = 1'b1; kill = 1'b1; opcode = 8'h20;
    eval();
    check("kill_upc",   64'(mc_upc),     64'(12'h041));
    check("kill_ctrl",  64'(mc_control), 64'(0));
    check("kill_valid", 64'(mc_valid),   64'(0));
    check("kill_more",  64'(mc_more),    64'(0));
    clk_edge();
    mc_stall = 1'b0; kill = 1'b0;
    eval();
    check("kill_dispatch", 64'(mc_upc), 64'(12'h104));

    // Invalid label gives bubbles indefinitely.
    kill = 1'b1; opcode = 8'h33;
    clk_edge();
    kill = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eval();
      check("bubble_valid", 64'(mc_valid),   64'(0));
      check("bubble_ctrl",  64'(mc_control), 64'(0));
      clk_edge();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int pick;
      mode     = MODE_W'($urandom_range(0, 1));
      pick     = $urandom_range(0, 3);
      opcode   = (pick == 0) ? 8'h12 : (pick == 1) ? 8'h20 : (pick == 2) ? 8'h33 : OP_W'($urandom);
      cond     = NCOND'($urandom);
      mc_stall = ($urandom_range(0, 4) == 0);
      kill     = ($urandom_range(0, 19) == 0);
      cs_we    = ($urandom_range(0, 5) == 0);
      cs_addr  = (pick < 2) ? UPC_W'(12'h040 + $urandom_range(0, 7)) : UPC_W'($urandom);
      cs_wdata = (pick < 3) ? mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                                 12'h040 + $urandom_range(0, 7))
                            : CTRL_W'($urandom);
      lbl_we   = ($urandom_range(0, 14) == 0);
      lbl_addr = LBL_W'({mode, opcode});
      lbl_wdata = (UPC_W + 1)'({$urandom_range(0, 1), 10'h040 + 10'($urandom_range(0, 7))});
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
